// File: rtl/reconfig_pkg.sv
// Shared types for the internal reconfiguration responder:
// FSM states, error codes and the image-select type.
package reconfig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_PULSE,
    ST_LOAD,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef logic [1:0] img_t;
  typedef logic [1:0] err_t;

  localparam err_t ERR_NONE    = 2'd0;
  localparam err_t ERR_INVALID = 2'd1;
  localparam err_t ERR_SHORT   = 2'd2;
  localparam err_t ERR_ABORT   = 2'd3;

endpackage

// File: rtl/reconfig_load_timer.sv
// LOAD residency counter: clears, counts while enabled,
// and stops at LOAD_CYCLES-1 instead of wrapping.
module reconfig_load_timer #(
  parameter int unsigned LOAD_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned W = $clog2(LOAD_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(LOAD_CYCLES - 1);

  logic [W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/internal_reconfig_responder.sv
// Responds to an image reconfiguration request: qualifies the
// trigger pulse, checks the image, times the load, reports errors.
module internal_reconfig_responder
  import reconfig_pkg::*;
#(
  parameter int unsigned LOAD_CYCLES     = 16,
  parameter int unsigned CONFIG_MIN_HIGH = 4,
  parameter logic [3:0]  VALID_MASK      = 4'b0011
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cfg_ENA,
  input  logic [1:0] cfg_CBSEL,
  input  logic       cfg_CONFIG,
  output logic       cfg_ERROR,
  output logic [1:0] error_code,
  output logic       busy,
  output logic       reconfig_done,
  output logic [1:0] active_image
);

  localparam int unsigned HW = $clog2(CONFIG_MIN_HIGH + 1);
  localparam logic [HW-1:0] HI_MAX = HW'(CONFIG_MIN_HIGH);

  state_t        state, state_d;
  err_t          err_d;
  img_t          sel_q, sel_d;
  logic [HW-1:0] hi_q, hi_d;
  logic          cfg_CONFIG_q;
  logic          rise;
  logic          load_tc;

  assign rise = cfg_CONFIG && !cfg_CONFIG_q;

  reconfig_load_timer #(
    .LOAD_CYCLES(LOAD_CYCLES)
  ) u_timer (
    .clk (clk),
    .rstn(rstn),
    .clr (state != ST_LOAD),
    .en  (state == ST_LOAD),
    .tc  (load_tc)
  );

  always_comb begin
    state_d = state;
    err_d   = error_code;
    sel_d   = sel_q;
    hi_d    = hi_q;
    unique case (state)
      ST_IDLE: begin
        if (cfg_ENA) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (!cfg_ENA) begin
          state_d = ST_IDLE;
        end else if (rise) begin
          state_d = ST_PULSE;
          sel_d   = cfg_CBSEL;
          hi_d    = HW'(1);
        end
      end
      ST_PULSE: begin
        // select change or enable loss outranks pulse-width checks
        if (cfg_CBSEL != sel_q || !cfg_ENA) begin
          state_d = ST_ERROR;
          err_d   = ERR_ABORT;
        end else if (cfg_CONFIG) begin
          if (hi_q != HI_MAX) hi_d = hi_q + 1'b1;
        end else if (hi_q < HI_MAX) begin
          state_d = ST_ERROR;
          err_d   = ERR_SHORT;
        end else if (!VALID_MASK[sel_q]) begin
          state_d = ST_ERROR;
          err_d   = ERR_INVALID;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!cfg_ENA || rise) begin
          state_d = ST_ERROR;
          err_d   = ERR_ABORT;
        end else if (load_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = cfg_ENA ? ST_ARMED : ST_IDLE;
      end
      ST_ERROR: begin
        if (!cfg_ENA) begin
          state_d = ST_IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        err_d   = ERR_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      error_code    <= ERR_NONE;
      sel_q         <= '0;
      hi_q          <= '0;
      cfg_CONFIG_q  <= 1'b0;
      cfg_ERROR     <= 1'b0;
      busy          <= 1'b0;
      reconfig_done <= 1'b0;
      active_image  <= '0;
    end else begin
      state         <= state_d;
      error_code    <= err_d;
      sel_q         <= sel_d;
      hi_q          <= hi_d;
      cfg_CONFIG_q  <= cfg_CONFIG;
      cfg_ERROR     <= (state_d == ST_ERROR);
      busy          <= (state_d == ST_PULSE) || (state_d == ST_LOAD);
      reconfig_done <= (state_d == ST_DONE);
      if (state == ST_DONE) active_image <= sel_q;
    end
  end

endmodule

// File: tb/tb_internal_reconfig_responder.sv
// Directed bench for internal_reconfig_responder with default
// parameters (16 load cycles, min high 4, images 0 and 1 valid).
module tb_internal_reconfig_responder;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_ENA;
  logic [1:0] cfg_CBSEL;
  logic       cfg_CONFIG;
  logic       cfg_ERROR;
  logic [1:0] error_code;
  logic       busy;
  logic       reconfig_done;
  logic [1:0] active_image;

  int n_chk  = 0;
  int n_pass = 0;
  int nb, nd, nb2, nd2;

  always #5 clk = ~clk;

  internal_reconfig_responder dut (
    .clk          (clk),
    .rstn         (rstn),
    .cfg_ENA      (cfg_ENA),
    .cfg_CBSEL    (cfg_CBSEL),
    .cfg_CONFIG   (cfg_CONFIG),
    .cfg_ERROR    (cfg_ERROR),
    .error_code   (error_code),
    .busy         (busy),
    .reconfig_done(reconfig_done),
    .active_image (active_image)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // trigger high for hi sampled edges, then observe win edges total
  task automatic run_req(input logic [1:0] sel, input int hi,
                         input int win, output int nbusy,
                         output int ndone);
    cfg_CBSEL  = sel;
    cfg_CONFIG = 1'b1;
    nbusy = 0;
    ndone = 0;
    for (int i = 0; i < win; i++) begin
      @(posedge clk);
      #1;
      if (i == hi - 1) cfg_CONFIG = 1'b0;
      nbusy += int'(busy);
      ndone += int'(reconfig_done);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_err"},  32'(cfg_ERROR),     0);
    check({tag, "_code"}, 32'(error_code),    0);
    check({tag, "_busy"}, 32'(busy),          0);
    check({tag, "_done"}, 32'(reconfig_done), 0);
    check({tag, "_img"},  32'(active_image),  0);
  endtask

  initial begin
    rstn       = 1'b0;
    cfg_ENA    = 1'b0;
    cfg_CBSEL  = 2'd0;
    cfg_CONFIG = 1'b0;
    #3;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // valid request, image 1
    cfg_ENA = 1'b1;
    tick();
    run_req(2'd1, 4, 30, nb, nd);
    check("ok_busy_cycles", 32'(nb), 20);
    check("ok_done_pulses", 32'(nd), 1);
    check("ok_image",       32'(active_image), 1);
    check("ok_err",         32'(cfg_ERROR), 0);

    // back-to-back valid requests, images 0 then 1
    run_req(2'd0, 4, 22, nb, nd);
    check("b2b_img0", 32'(active_image), 0);
    run_req(2'd1, 4, 22, nb2, nd2);
    check("b2b_dones", 32'(nd + nd2), 2);
    check("b2b_img1",  32'(active_image), 1);

    // invalid image with long pulse
    run_req(2'd2, 6, 8, nb, nd);
    check("inv_err",  32'(cfg_ERROR), 1);
    check("inv_code", 32'(error_code), 1);
    check("inv_done", 32'(nd), 0);
    cfg_CONFIG = 1'b1;
    tick();
    cfg_CONFIG = 1'b0;
    tick();
    check("err_ignore_cfg", 32'(error_code), 1);
    cfg_ENA = 1'b0;
    tick();
    check("inv_clr_err",  32'(cfg_ERROR), 0);
    check("inv_clr_code", 32'(error_code), 0);

    // short pulse
    cfg_ENA = 1'b1;
    tick();
    run_req(2'd1, 2, 6, nb, nd);
    check("short_err",  32'(cfg_ERROR), 1);
    check("short_code", 32'(error_code), 2);
    check("short_img",  32'(active_image), 1);
    cfg_ENA = 1'b0;
    tick();

    // enable dropped at load cycle 8
    cfg_ENA = 1'b1;
    tick();
    run_req(2'd0, 4, 12, nb, nd);
    check("ena_in_load", 32'(busy), 1);
    cfg_ENA = 1'b0;
    tick();
    check("ena_err",  32'(cfg_ERROR), 1);
    check("ena_code", 32'(error_code), 3);
    check("ena_done", 32'(nd + int'(reconfig_done)), 0);
    check("ena_busy", 32'(busy), 0);
    tick();
    check("ena_clr", 32'(cfg_ERROR), 0);
    check("ena_img", 32'(active_image), 1);

    // select changed mid-pulse
    cfg_ENA = 1'b1;
    tick();
    cfg_CBSEL  = 2'd1;
    cfg_CONFIG = 1'b1;
    tick(2);
    check("sel_pulse_busy", 32'(busy), 1);
    cfg_CBSEL = 2'd3;
    tick();
    check("sel_err",  32'(cfg_ERROR), 1);
    check("sel_code", 32'(error_code), 3);
    cfg_ENA    = 1'b0;
    cfg_CONFIG = 1'b0;
    tick();

    // reset at load cycle 10, trigger held high through release
    cfg_ENA = 1'b1;
    tick();
    run_req(2'd0, 4, 14, nb, nd);
    check("rst_in_load", 32'(busy), 1);
    rstn       = 1'b0;
    cfg_CONFIG = 1'b1;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rstn = 1'b1;
    nb = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      nb += int'(busy);
    end
    check("rel_no_edge", 32'(nb), 0);
    check("rel_no_err",  32'(cfg_ERROR), 0);
    cfg_CONFIG = 1'b0;
    tick();
    cfg_CONFIG = 1'b1;
    tick();
    check("rel_new_edge", 32'(busy), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/internal_reconfig_responder.md
INTERNAL_RECONFIG_RESPONDER -- requirements
Module: internal_reconfig_responder

Interface
REQ-001 Parameter LOAD_CYCLES, default 16: cycles spent in LOAD before completion, legal range 1..65535.
REQ-002 Parameter CONFIG_MIN_HIGH, default 4: minimum cfg_CONFIG high width in cycles, legal range 1..255.
REQ-003 Parameter VALID_MASK, default 4'b0011: bit i set means image i is loadable.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 cfg_ENA  input  1  reconfiguration enable from the requesting image.
REQ-007 cfg_CBSEL  input  2  requested image select.
REQ-008 cfg_CONFIG  input  1  reconfiguration trigger pulse.
REQ-009 cfg_ERROR  output  1  request rejected or aborted; level output.
REQ-010 error_code  output  2  0=none, 1=invalid image, 2=short pulse, 3=abort/select change.
REQ-011 busy  output  1  high in PULSE or LOAD.
REQ-012 reconfig_done  output  1  one-cycle completion pulse.
REQ-013 active_image  output  2  last successfully loaded image.

Function
REQ-014 All inputs are synchronous to clk; cfg_CONFIG is edge-detected against a registered copy, cfg_CONFIG_q.
REQ-015 The FSM states are IDLE, ARMED, PULSE, LOAD, DONE and ERROR.
REQ-016 IDLE -> ARMED when cfg_ENA=1.
REQ-017 ARMED -> IDLE when cfg_ENA=0.
REQ-018 ARMED -> PULSE on cfg_CONFIG=1 with cfg_CONFIG_q=0; cfg_CBSEL is captured into sel_q and the high counter is loaded with 1.
REQ-019 In PULSE, while cfg_CONFIG=1 the high counter increments and saturates at CONFIG_MIN_HIGH.
REQ-020 PULSE -> ERROR (code 3) if cfg_CBSEL differs from sel_q or cfg_ENA=0, taking priority over all other PULSE checks.
REQ-021 In PULSE, when cfg_CONFIG=0: if high count < CONFIG_MIN_HIGH -> ERROR (code 2); else if VALID_MASK[sel_q]=0 -> ERROR (code 1); else -> LOAD with the load counter cleared.
REQ-022 In LOAD, the load counter increments each cycle; when it equals LOAD_CYCLES-1 -> DONE; total LOAD residency is exactly LOAD_CYCLES cycles.
REQ-023 In LOAD, cfg_ENA=0 or a new cfg_CONFIG rising edge -> ERROR (code 3); abort takes priority over completion in the same cycle.
REQ-024 DONE lasts one cycle: reconfig_done=1 and active_image<=sel_q, then -> ARMED if cfg_ENA=1, else IDLE.
REQ-025 In ERROR, cfg_ERROR=1 and error_code is held until cfg_ENA=0 -> IDLE; both clear on that exit.
REQ-026 cfg_CONFIG activity in IDLE or ERROR is ignored and does not alter error_code.
REQ-027 The load counter width is clog2(LOAD_CYCLES+1) and never wraps.
REQ-028 The high counter width is clog2(CONFIG_MIN_HIGH+1) and saturates rather than wraps.
REQ-029 Outputs are registered; cfg_ERROR, busy and reconfig_done reflect the state register with zero added latency.

Reset
REQ-030 On rstn=0, asynchronously: state=IDLE, cfg_ERROR=0, error_code=0, busy=0, reconfig_done=0, active_image=0, sel_q=0, both counters=0, cfg_CONFIG_q=0.
REQ-031 Reset asserted mid-PULSE or mid-LOAD abandons the request with no done pulse and no change to active_image beyond its reset value.
REQ-032 The first cycle after rstn deasserts evaluates IDLE; a cfg_CONFIG already high is not treated as an edge, because cfg_CONFIG_q must first observe 0.

Structure
REQ-033 Package reconfig_pkg holds the state enum, the error-code constants and the 2-bit image-select type.
REQ-034 Sub-module reconfig_load_timer holds the parameterized LOAD counter with clear, enable and terminal-count outputs.
REQ-035 Target size is 150-300 lines of RTL.

Verification (LOAD_CYCLES=16, CONFIG_MIN_HIGH=4, VALID_MASK=4'b0011)
REQ-036 ENA=1, CBSEL=1, CONFIG high 4 cycles -> busy for 4+16 cycles, reconfig_done pulses once, active_image=1, cfg_ERROR=0.
REQ-037 CBSEL=2, CONFIG high 6 cycles -> cfg_ERROR=1 with code 1 after CONFIG falls; ENA low -> cfg_ERROR=0 next cycle.
REQ-038 CONFIG high 2 cycles -> cfg_ERROR=1 with code 2; active_image unchanged.
REQ-039 ENA dropped at LOAD cycle 8 -> cfg_ERROR=1 with code 3 and no done pulse; CBSEL toggled mid-PULSE -> code 3.
REQ-040 rstn pulsed low at LOAD cycle 10 -> all outputs 0 immediately; CONFIG held high through release causes no edge.
REQ-041 Two back-to-back valid requests (images 0 then 1) with ENA held high -> two done pulses, and active_image ends at 1.
